reg_stack: RTL and testbench

- 8-bit hardware LIFO that sits directly upstream of the CPU's 8-bit register stage.
- Holds call/return and scratch values. Its top-of-stack output drives the data input of the downstream register, and the push/pop strobes come from the control decoder.
- Provides full/empty status, occupancy count, and sticky overflow/underflow error flags.

---
 rtl/reg_stack_pkg.sv | 27 ++
 rtl/reg_stack_mem.sv | 34 +++
 rtl/reg_stack.sv | 144 ++++++++++++++
 tb/tb_reg_stack.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_stack_pkg.sv
// Shared defaults, operation encoding and decode helper for the reg_stack LIFO.
package reg_stack_pkg;

   localparam int unsigned STACK_WIDTH = 8;
   localparam int unsigned STACK_DEPTH = 8;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_PUSH,
      OP_POP,
      OP_REPLACE
   } stack_op_t;

   // Map the raw {push,pop} strobes onto a stack operation.
   function automatic stack_op_t decode_op(input logic push, input logic pop);
      stack_op_t op;
      op = OP_NOP;
      case ({push, pop})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_REPLACE;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/reg_stack_mem.sv
// DEPTH x WIDTH storage for reg_stack: one synchronous write port, async reads, no reset.
// Optional second read port exists only when REG_STACK_PEEK_EN is defined.
module reg_stack_mem #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
`ifdef REG_STACK_PEEK_EN
   input  logic [AW-1:0]    peek_raddr_i,
   output logic [WIDTH-1:0] peek_rdata_o,
`endif
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

`ifdef REG_STACK_PEEK_EN
   assign peek_rdata_o = mem_q[peek_raddr_i];
`endif

endmodule

// File: rtl/reg_stack.sv
// 8-bit LIFO feeding the register stage: registered top-of-stack, count, status and sticky errors.
// Define REG_STACK_PEEK_EN to add the peek_idx/peek_data random-read port.
module reg_stack
   import reg_stack_pkg::*;
#(
   parameter int unsigned WIDTH = STACK_WIDTH,
   parameter int unsigned DEPTH = STACK_DEPTH,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   input  logic                     clr_err,
`ifdef REG_STACK_PEEK_EN
   input  logic [$clog2(DEPTH)-1:0] peek_idx,
   output logic [WIDTH-1:0]         peek_data,
`endif
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [CW-1:0]            count,
   output logic                     ovf,
   output logic                     udf
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;

   stack_op_t        op_c;
   logic             we_c;
   logic [AW-1:0]    waddr_c;
   logic [AW-1:0]    raddr_c;
   logic [WIDTH-1:0] rdata_c;

   assign op_c    = decode_op(push, pop);
   // Entry just below the top; only consumed by a pop with count > 1.
   assign raddr_c = AW'(count_q - CW'(2));

`ifdef REG_STACK_PEEK_EN
   logic [AW-1:0]    peek_raddr_c;
   logic [WIDTH-1:0] peek_rdata_c;

   assign peek_raddr_c = AW'(count_q - CW'(1) - CW'(peek_idx));
   assign peek_data    = (CW'(peek_idx) >= count_q) ? '0 : peek_rdata_c;
`endif

   reg_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk          (clk),
      .we_i         (we_c),
      .waddr_i      (waddr_c),
      .wdata_i      (din),
`ifdef REG_STACK_PEEK_EN
      .peek_raddr_i (peek_raddr_c),
      .peek_rdata_o (peek_rdata_c),
`endif
      .raddr_i      (raddr_c),
      .rdata_o      (rdata_c)
   );

   // Operation decode, pointer/count update and sticky error handling.
   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      ovf_d   = ovf_q & ~clr_err;
      udf_d   = udf_q & ~clr_err;
      we_c    = 1'b0;
      waddr_c = AW'(count_q);

      case (op_c)
         OP_PUSH: begin
            if (full_q) begin
               ovf_d = 1'b1;
            end else begin
               we_c    = 1'b1;
               count_d = count_q + CW'(1);
               dout_d  = din;
            end
         end
         OP_POP: begin
            if (empty_q) begin
               udf_d = 1'b1;
            end else if (count_q == CW'(1)) begin
               count_d = '0;
               dout_d  = '0;
            end else begin
               count_d = count_q - CW'(1);
               dout_d  = rdata_c;
            end
         end
         OP_REPLACE: begin
            // Replace on an empty stack degrades to a plain push.
            we_c   = 1'b1;
            dout_d = din;
            if (empty_q) begin
               count_d = CW'(1);
            end else begin
               waddr_c = AW'(count_q - CW'(1));
            end
         end
         default: ;
      endcase

      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         dout_q  <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign dout  = dout_q;
   assign count = count_q;
   assign empty = empty_q;
   assign full  = full_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

endmodule

// File: tb/tb_reg_stack.sv
// Bench for reg_stack: directed vector table, full-stack corner sequence, then a queue-model random run.
// Peek checks are compiled in when REG_STACK_PEEK_EN is defined.
module tb_reg_stack;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 8;
   localparam int unsigned CW = 4;

   logic         clk = 1'b0;
   logic         rst_n, push, pop, clr_err;
   logic [W-1:0] din, dout;
   logic         empty, full, ovf, udf;
   logic [CW-1:0] count;
`ifdef REG_STACK_PEEK_EN
   logic [2:0]   peek_idx;
   logic [W-1:0] peek_data;
`endif

   always #5 clk = ~clk;

   reg_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .clr_err   (clr_err),
`ifdef REG_STACK_PEEK_EN
      .peek_idx  (peek_idx),
      .peek_data (peek_data),
`endif
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .ovf       (ovf),
      .udf       (udf)
   );

   typedef struct packed {
      logic [W-1:0]  dout;
      logic [CW-1:0] count;
      logic          empty;
      logic          full;
      logic          ovf;
      logic          udf;
   } exp_t;

   typedef struct {
      string        name;
      logic         rst_n, push, pop, clr;
      logic [W-1:0] din;
      exp_t         exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic exp_t mk_exp(logic [W-1:0] d, int c, bit e, bit f, bit o, bit u);
      exp_t x;
      x.dout = d; x.count = CW'(c); x.empty = e; x.full = f; x.ovf = o; x.udf = u;
      return x;
   endfunction

   function automatic void add(string nm, bit r, bit p, bit q, bit c, logic [W-1:0] d,
                               logic [W-1:0] ed, int ec, bit ee, bit ef, bit eo, bit eu);
      vec_t v;
      v.name = nm; v.rst_n = r; v.push = p; v.pop = q; v.clr = c; v.din = d;
      v.exp  = mk_exp(ed, ec, ee, ef, eo, eu);
      vecs.push_back(v);
   endfunction

   task automatic drive(bit r, bit p, bit q, bit c, logic [W-1:0] d);
      rst_n = r; push = p; pop = q; clr_err = c; din = d;
   endtask

   // Pop the oldest expectation and compare against the settled outputs.
   task automatic check(string nm);
      exp_t e, a;
      n_vec++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s: no expected entry in scoreboard", nm);
         return;
      end
      e = sb.pop_front();
      a = {dout, count, empty, full, ovf, udf};
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got dout=%h count=%0d empty=%b full=%b ovf=%b udf=%b, expected dout=%h count=%0d empty=%b full=%b ovf=%b udf=%b",
                  nm, a.dout, a.count, a.empty, a.full, a.ovf, a.udf,
                  e.dout, e.count, e.empty, e.full, e.ovf, e.udf);
      end
   endtask

   task automatic step(string nm, bit r, bit p, bit q, bit c, logic [W-1:0] d, exp_t e);
      drive(r, p, q, c, d);
      sb.push_back(e);
      @(posedge clk);
      #1;
      check(nm);
   endtask

   logic [W-1:0] model[$];
   bit           m_ovf, m_udf;

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
`ifdef REG_STACK_PEEK_EN
      peek_idx = 3'd0;
`endif

      add("reset",      0,0,0,0, 8'h00, 8'h00,0,1,0,0,0);
      add("push11",     1,1,0,0, 8'h11, 8'h11,1,0,0,0,0);
      add("push22",     1,1,0,0, 8'h22, 8'h22,2,0,0,0,0);
      add("push33",     1,1,0,0, 8'h33, 8'h33,3,0,0,0,0);
      add("pop_to22",   1,0,1,0, 8'h00, 8'h22,2,0,0,0,0);
      add("pop_to11",   1,0,1,0, 8'h00, 8'h11,1,0,0,0,0);
      add("pop_last",   1,0,1,0, 8'h00, 8'h00,0,1,0,0,0);
      for (int i = 0; i < 8; i++)
         add($sformatf("fill%0d", i), 1,1,0,0, W'(8'hA0 + i), W'(8'hA0 + i), i + 1, 0, (i == 7), 0, 0);
      add("push_full",  1,1,0,0, 8'hFF, 8'hA7,8,0,1,1,0);
      add("pop_afull",  1,0,1,0, 8'h00, 8'hA6,7,0,0,1,0);
      add("nop_ovf",    1,0,0,0, 8'h5A, 8'hA6,7,0,0,1,0);
      add("clr_ovf",    1,0,0,1, 8'h00, 8'hA6,7,0,0,0,0);
      for (int i = 0; i < 7; i++)
         add($sformatf("drain%0d", i), 1,0,1,0, 8'h00, (i == 6) ? 8'h00 : W'(8'hA5 - i), 6 - i, (i == 6), 0, 0, 0);
      add("udf_clr_win",1,0,1,1, 8'h00, 8'h00,0,1,0,0,1);
      add("clr_udf",    1,0,0,1, 8'h00, 8'h00,0,1,0,0,0);
      add("push05",     1,1,0,0, 8'h05, 8'h05,1,0,0,0,0);
      add("push06",     1,1,0,0, 8'h06, 8'h06,2,0,0,0,0);
      add("replace77",  1,1,1,0, 8'h77, 8'h77,2,0,0,0,0);
      add("pop_to05",   1,0,1,0, 8'h00, 8'h05,1,0,0,0,0);
      add("pop_empty",  1,0,1,0, 8'h00, 8'h00,0,1,0,0,0);
      add("repl_empty", 1,1,1,0, 8'h44, 8'h44,1,0,0,0,0);
      add("repl_one",   1,1,1,0, 8'h55, 8'h55,1,0,0,0,0);
      add("pop_one",    1,0,1,0, 8'h00, 8'h00,0,1,0,0,0);
      add("udf_set",    1,0,1,0, 8'h00, 8'h00,0,1,0,0,1);
      for (int i = 0; i < 5; i++)
         add($sformatf("pre_rst%0d", i), 1,1,0,0, W'(8'h91 + i), W'(8'h91 + i), i + 1, 0, 0, 0, 1);
      add("rst_midop",  0,1,0,0, 8'h99, 8'h00,0,1,0,0,0);
      add("udf_again",  1,0,1,0, 8'h00, 8'h00,0,1,0,0,1);

      foreach (vecs[i]) begin
         step(vecs[i].name, vecs[i].rst_n, vecs[i].push, vecs[i].pop, vecs[i].clr,
              vecs[i].din, vecs[i].exp);
      end

      // Full stack: replace must overwrite the top without counting an overflow.
      step("seq_rst", 0,0,0,0, 8'h00, mk_exp(8'h00, 0, 1, 0, 0, 0));
      for (int i = 0; i < 8; i++)
         step("seq_fill", 1,1,0,0, W'(8'hC0 + i), mk_exp(W'(8'hC0 + i), i + 1, 0, (i == 7), 0, 0));
      step("seq_repl_full", 1,1,1,0, 8'hEE, mk_exp(8'hEE, 8, 0, 1, 0, 0));
      step("seq_pop_full",  1,0,1,0, 8'h00, mk_exp(8'hC6, 7, 0, 0, 0, 0));
      step("seq_repush",    1,1,0,0, 8'h3C, mk_exp(8'h3C, 8, 0, 1, 0, 0));
      step("seq_ovf_clr",   1,1,0,1, 8'h01, mk_exp(8'h3C, 8, 0, 1, 1, 0));
      step("seq_rst_full",  0,1,1,1, 8'h02, mk_exp(8'h00, 0, 1, 0, 0, 0));

`ifdef REG_STACK_PEEK_EN
      peek_idx = 3'd2;
      #1;
      n_vec++;
      if (peek_data !== 8'h00) begin
         n_bad++;
         $display("FAIL peek_after_rst: got %h expected 00", peek_data);
      end
`endif

      // Random run against a queue-based reference stack.
      model.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      for (int n = 0; n < 400; n++) begin
         bit           p, q, c, o_set, u_set;
         logic [W-1:0] d;
         exp_t         e;
         p = ($urandom_range(0, 9) < 6);
         q = ($urandom_range(0, 9) < 5);
         c = ($urandom_range(0, 7) == 0);
         d = W'($urandom);
         o_set = 1'b0;
         u_set = 1'b0;
         if (p && !q) begin
            if (model.size() == D) o_set = 1'b1;
            else model.push_back(d);
         end else if (!p && q) begin
            if (model.size() == 0) u_set = 1'b1;
            else void'(model.pop_back());
         end else if (p && q) begin
            if (model.size() == 0) model.push_back(d);
            else model[model.size() - 1] = d;
         end
         m_ovf = o_set | (m_ovf & ~c);
         m_udf = u_set | (m_udf & ~c);
         e = mk_exp((model.size() == 0) ? W'(0) : model[model.size() - 1], model.size(),
                    (model.size() == 0), (model.size() == D), m_ovf, m_udf);
`ifdef REG_STACK_PEEK_EN
         peek_idx = 3'($urandom_range(0, 7));
`endif
         step("rand", 1, p, q, c, d, e);
`ifdef REG_STACK_PEEK_EN
         begin
            logic [W-1:0] pe;
            pe = (int'(peek_idx) < model.size()) ? model[model.size() - 1 - int'(peek_idx)] : W'(0);
            n_vec++;
            if (peek_data !== pe) begin
               n_bad++;
               $display("FAIL rand_peek idx=%0d: got %h expected %h", peek_idx, peek_data, pe);
            end
         end
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
